// File: rtl/decim2_d4_cic.sv
// Decimate-by-4, two-stage CIC with gain normalisation (/16, round half up)
// and a one-entry valid/ready output register.
module decim2_d4_cic #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_bits     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            phase
);

  localparam int unsigned AW = DATA_WIDTH + N_bits;  // integrator/comb width
  localparam int unsigned RW = AW + 1;                // rounding headroom
  localparam int unsigned SW = RW - N_bits;           // width after normalising shift

  logic signed [AW-1:0]         i1;
  logic signed [AW-1:0]         i2;
  logic signed [AW-1:0]         d_z;
  logic signed [AW-1:0]         c1_z;
  logic signed [AW-1:0]         i1_next;
  logic signed [AW-1:0]         i2_next;
  logic signed [AW-1:0]         c1;
  logic signed [AW-1:0]         c2;
  logic signed [RW-1:0]         rnd;
  logic signed [SW-1:0]         shf;
  logic                         fits;
  logic [DATA_WIDTH-1:0]        sat;
  logic                         accept;
  logic                         dec_evt;
  logic                         out_hs;

  // Only the 4th sample of a group needs the output slot, so only it stalls.
  assign s_ready = en && !((phase == 2'd3) && m_valid && !m_ready);
  assign accept  = s_valid && s_ready;
  assign dec_evt = accept && (phase == 2'd3);
  assign out_hs  = m_valid && m_ready;

  // Integrator and comb datapath, all modulo 2^AW.
  always_comb begin
    i1_next = i1 + AW'($signed(s_data));
    i2_next = i2 + i1_next;
    c1      = i2_next - d_z;
    c2      = c1 - c1_z;
  end

  // Gain normalise with round half up, then saturate to the output range.
  always_comb begin
    rnd  = RW'(c2) + RW'(1 << (N_bits - 1));
    shf  = SW'(rnd >>> N_bits);
    fits = (shf[SW-1:DATA_WIDTH-1] == {(SW - DATA_WIDTH + 1){shf[SW-1]}});
    if (fits) begin
      sat = shf[DATA_WIDTH-1:0];
    end else if (shf[SW-1]) begin
      sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      i1      <= '0;
      i2      <= '0;
      d_z     <= '0;
      c1_z    <= '0;
      phase   <= 2'd0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (accept) begin
        i1    <= i1_next;
        i2    <= i2_next;
        phase <= phase + 2'd1;
      end
      // A new result wins over a simultaneous drain, so m_valid stays high.
      if (dec_evt) begin
        d_z     <= i2_next;
        c1_z    <= c1;
        m_data  <= sat;
        m_valid <= 1'b1;
      end else if (out_hs) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decim2_d4_cic.sv
// Scoreboard bench for decim2_d4_cic: directed groups with hand-computed outputs.
module tb_decim2_d4_cic;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          en;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    phase;

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  decim2_d4_cic #(.DATA_WIDTH(DW), .N_bits(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .en      (en),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .phase   (phase)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: an output handshake happens at the next posedge.
  always @(negedge clk) begin
    if (!rst && !clear && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %0h expected none", m_data);
      end else begin
        check("m_data", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    logic r;
    s_valid = 1'b1;
    s_data  = d;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      if (r) return;
    end
    n_total++;
    $display("FAIL send_timeout: got stalled expected accept");
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    clear   = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_m_valid", DW'(m_valid), DW'(0));
    check("rst_m_data", m_data, '0);
    check("rst_phase", DW'(phase), DW'(0));
    check("rst_s_ready", DW'(s_ready), DW'(en));
  endtask

  task automatic drain();
    s_valid = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst     = 1'b1;
    clear   = 1'b0;
    en      = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;

    // Step response with one-cycle latency checks.
    do_reset();
    exp_q.push_back(32'd63);
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd100);
    for (int i = 1; i <= 12; i++) begin
      send(32'd100);
      check("step_phase", DW'(phase), DW'(i % 4));
      if (i % 4 == 0) check("step_latency", DW'(m_valid), DW'(1));
    end
    drain();

    // Backpressure: 4th sample stalls, then loads with no bubble.
    do_reset();
    exp_q.push_back(32'd63);
    exp_q.push_back(32'd100);
    for (int i = 0; i < 4; i++) send(32'd100);
    m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      send(32'd100);
      check("bp_phase", DW'(phase), DW'(i));
    end
    s_valid = 1'b1;
    s_data  = 32'd100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_s_ready", DW'(s_ready), DW'(0));
      check("bp_hold", m_data, 32'd63);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", DW'(s_ready), DW'(1));
    @(posedge clk);
    #1;
    check("bp_no_bubble", DW'(m_valid), DW'(1));
    check("bp_new_data", m_data, 32'd100);
    check("bp_phase_wrap", DW'(phase), DW'(0));
    drain();

    // Negative step: round half up.
    do_reset();
    exp_q.push_back(-32'sd62);
    exp_q.push_back(-32'sd100);
    for (int i = 0; i < 8; i++) send(-32'sd100);
    drain();

    // Mid-group clear discards the partial group.
    do_reset();
    send(32'd500);
    send(32'd500);
    s_valid = 1'b0;
    clear   = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_phase", DW'(phase), DW'(0));
    check("clr_m_valid", DW'(m_valid), DW'(0));
    exp_q.push_back(32'd63);
    for (int i = 0; i < 4; i++) send(32'd100);
    drain();

    // en low freezes the front end while the pending output drains.
    do_reset();
    m_ready = 1'b0;
    exp_q.push_back(32'd63);
    for (int i = 0; i < 6; i++) send(32'd100);
    en      = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'd100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en_s_ready", DW'(s_ready), DW'(0));
      check("en_phase", DW'(phase), DW'(2));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("en_drained", DW'(m_valid), DW'(0));
    check("en_phase_hold", DW'(phase), DW'(2));
    en = 1'b1;
    exp_q.push_back(32'd100);
    send(32'd100);
    send(32'd100);
    check("en_resume_valid", DW'(m_valid), DW'(1));
    drain();

    // Full-scale input: integrators wrap, outputs stay exact.
    do_reset();
    exp_q.push_back(32'h4FFF_FFFF);
    for (int i = 1; i < 1024; i++) exp_q.push_back(32'h7FFF_FFFF);
    for (int i = 0; i < 4096; i++) send(32'h7FFF_FFFF);
    drain();

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
